// File: rtl/butterfly_pipe.sv
// Three-stage pipelined radix-2 DIT butterfly with valid/ready handshake, optional /2 scaling,
// IFFT conjugation and overflow flag. Define BUTTERFLY_PIPE_SAT_EN to saturate instead of wrap.
module butterfly_pipe #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned TW_W   = 12,
  parameter int unsigned TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] xm_re,
  input  logic [DATA_W-1:0] xm_im,
  input  logic [DATA_W-1:0] xn_re,
  input  logic [DATA_W-1:0] xn_im,
  input  logic [TW_W-1:0]   tw_re,
  input  logic [TW_W-1:0]   tw_im,
  input  logic              inv,
  input  logic              scale,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ym_re,
  output logic [DATA_W-1:0] ym_im,
  output logic [DATA_W-1:0] yn_re,
  output logic [DATA_W-1:0] yn_im,
  output logic [TAG_W-1:0]  out_tag,
  output logic              ovf
);

  localparam int unsigned WW  = TW_W + 1;
  localparam int unsigned PW  = DATA_W + TW_W + 2;
  localparam int unsigned SW  = DATA_W + 2;
  localparam int          RND = 2 ** (TW_W - 2);
  localparam logic signed [SW-1:0] MAX_V = SW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [SW-1:0] MIN_V = SW'(-(2 ** (DATA_W - 1)));

  logic adv;

  logic                     s1_valid_q;
  logic signed [DATA_W-1:0] s1_xm_re_q, s1_xm_im_q, s1_xn_re_q, s1_xn_im_q;
  logic signed [WW-1:0]     s1_wr_q, s1_wi_q;
  logic                     s1_scale_q;
  logic [TAG_W-1:0]         s1_tag_q;

  logic                     s2_valid_q;
  logic signed [PW-1:0]     s2_rr_q, s2_ii_q, s2_ri_q, s2_ir_q;
  logic signed [DATA_W-1:0] s2_xm_re_q, s2_xm_im_q;
  logic                     s2_scale_q;
  logic [TAG_W-1:0]         s2_tag_q;

  logic signed [PW-1:0] pr, pi;
  logic signed [SW-1:0] p_re, p_im;
  logic signed [SW-1:0] s_ym_re, s_ym_im, s_yn_re, s_yn_im;
  logic                 any_over;

  function automatic logic signed [SW-1:0] round_p(input logic signed [PW-1:0] prod);
    logic signed [PW-1:0] t;
    t = (prod + PW'(RND)) >>> (TW_W - 1);
    return t[SW-1:0];
  endfunction

  function automatic logic signed [SW-1:0] halve(input logic signed [SW-1:0] s,
                                                 input logic en);
    logic signed [SW-1:0] t;
    t = (s + SW'(1)) >>> 1;
    return en ? t : s;
  endfunction

  function automatic logic out_of_range(input logic signed [SW-1:0] s);
    return (s > MAX_V) || (s < MIN_V);
  endfunction

  function automatic logic [DATA_W-1:0] reduce(input logic signed [SW-1:0] s);
`ifdef BUTTERFLY_PIPE_SAT_EN
    if (s > MAX_V) begin
      return MAX_V[DATA_W-1:0];
    end else if (s < MIN_V) begin
      return MIN_V[DATA_W-1:0];
    end else begin
      return s[DATA_W-1:0];
    end
`else
    return s[DATA_W-1:0];
`endif
  endfunction

  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
  end

  always_comb begin
    pr       = s2_rr_q - s2_ii_q;
    pi       = s2_ri_q + s2_ir_q;
    p_re     = round_p(pr);
    p_im     = round_p(pi);
    s_ym_re  = halve(SW'(s2_xm_re_q) + p_re, s2_scale_q);
    s_ym_im  = halve(SW'(s2_xm_im_q) + p_im, s2_scale_q);
    s_yn_re  = halve(SW'(s2_xm_re_q) - p_re, s2_scale_q);
    s_yn_im  = halve(SW'(s2_xm_im_q) - p_im, s2_scale_q);
    any_over = out_of_range(s_ym_re) || out_of_range(s_ym_im) ||
               out_of_range(s_yn_re) || out_of_range(s_yn_im);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_xm_re_q <= '0;
      s1_xm_im_q <= '0;
      s1_xn_re_q <= '0;
      s1_xn_im_q <= '0;
      s1_wr_q    <= '0;
      s1_wi_q    <= '0;
      s1_scale_q <= 1'b0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_rr_q    <= '0;
      s2_ii_q    <= '0;
      s2_ri_q    <= '0;
      s2_ir_q    <= '0;
      s2_xm_re_q <= '0;
      s2_xm_im_q <= '0;
      s2_scale_q <= 1'b0;
      s2_tag_q   <= '0;
      out_valid  <= 1'b0;
      ym_re      <= '0;
      ym_im      <= '0;
      yn_re      <= '0;
      yn_im      <= '0;
      out_tag    <= '0;
      ovf        <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_xm_re_q <= xm_re;
      s1_xm_im_q <= xm_im;
      s1_xn_re_q <= xn_re;
      s1_xn_im_q <= xn_im;
      s1_wr_q    <= WW'($signed(tw_re));
      // One extra bit so that negating -2^(TW_W-1) stays exact.
      s1_wi_q    <= inv ? -WW'($signed(tw_im)) : WW'($signed(tw_im));
      s1_scale_q <= scale;
      s1_tag_q   <= in_tag;

      s2_valid_q <= s1_valid_q;
      s2_rr_q    <= PW'(s1_xn_re_q) * PW'(s1_wr_q);
      s2_ii_q    <= PW'(s1_xn_im_q) * PW'(s1_wi_q);
      s2_ri_q    <= PW'(s1_xn_re_q) * PW'(s1_wi_q);
      s2_ir_q    <= PW'(s1_xn_im_q) * PW'(s1_wr_q);
      s2_xm_re_q <= s1_xm_re_q;
      s2_xm_im_q <= s1_xm_im_q;
      s2_scale_q <= s1_scale_q;
      s2_tag_q   <= s1_tag_q;

      out_valid  <= s2_valid_q;
      ym_re      <= reduce(s_ym_re);
      ym_im      <= reduce(s_ym_im);
      yn_re      <= reduce(s_yn_re);
      yn_im      <= reduce(s_yn_im);
      out_tag    <= s2_tag_q;
      ovf        <= s2_valid_q && any_over;
    end
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboard bench for butterfly_pipe: directed cases plus randomized beats under random
// backpressure, checked against an integer reference model.
module tb_butterfly_pipe;

  localparam int DW  = 12;
  localparam int TW  = 12;
  localparam int TGW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0]  xm_re, xm_im, xn_re, xn_im;
  logic [TW-1:0]  tw_re, tw_im;
  logic           inv, scale, ovf;
  logic [TGW-1:0] in_tag, out_tag;
  logic [DW-1:0]  ym_re, ym_im, yn_re, yn_im;

  always #5 clk = ~clk;

  butterfly_pipe #(.DATA_W(DW), .TW_W(TW), .TAG_W(TGW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .xm_re(xm_re), .xm_im(xm_im), .xn_re(xn_re), .xn_im(xn_im),
    .tw_re(tw_re), .tw_im(tw_im), .inv(inv), .scale(scale), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .ym_re(ym_re), .ym_im(ym_im), .yn_re(yn_re), .yn_im(yn_im),
    .out_tag(out_tag), .ovf(ovf)
  );

  typedef struct {
    int xmr, xmi, xnr, xni, wr, wi;
    bit inv, sc;
    int tag;
  } beat_t;

  typedef struct {
    logic [DW-1:0]  ymr, ymi, ynr, yni;
    logic [TGW-1:0] tag;
    logic           ovf;
  } exp_t;

  exp_t  sb[$];
  exp_t  me;
  int    n_vec = 0;
  int    n_err = 0;
  bit    rnd_bp = 1'b0;

  function automatic int fdiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic logic [DW-1:0] fold(input int s);
    int lo, hi, m, r;
    lo = -(2 ** (DW - 1));
    hi = 2 ** (DW - 1) - 1;
    m  = 2 ** DW;
`ifdef BUTTERFLY_PIPE_SAT_EN
    r = (s > hi) ? hi : (s < lo) ? lo : s;
`else
    r = s - fdiv(s - lo, m) * m;
`endif
    return DW'(r);
  endfunction

  function automatic exp_t model(input beat_t b);
    int   wi, pr, pi, pre, pim;
    int   s[4];
    exp_t e;
    wi  = b.inv ? -b.wi : b.wi;
    pr  = b.xnr * b.wr - b.xni * wi;
    pi  = b.xnr * wi + b.xni * b.wr;
    pre = fdiv(pr + 2 ** (TW - 2), 2 ** (TW - 1));
    pim = fdiv(pi + 2 ** (TW - 2), 2 ** (TW - 1));
    s[0] = b.xmr + pre;
    s[1] = b.xmi + pim;
    s[2] = b.xmr - pre;
    s[3] = b.xmi - pim;
    e.ovf = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (b.sc) s[k] = fdiv(s[k] + 1, 2);
      if (s[k] < -(2 ** (DW - 1)) || s[k] > 2 ** (DW - 1) - 1) e.ovf = 1'b1;
    end
    e.ymr = fold(s[0]);
    e.ymi = fold(s[1]);
    e.ynr = fold(s[2]);
    e.yni = fold(s[3]);
    e.tag = TGW'(b.tag);
    return e;
  endfunction

  function automatic beat_t mkb(input int xmr, xmi, xnr, xni, wr, wi,
                                input bit iv, sc, input int tag);
    beat_t b;
    b.xmr = xmr; b.xmi = xmi; b.xnr = xnr; b.xni = xni;
    b.wr = wr; b.wi = wi; b.inv = iv; b.sc = sc; b.tag = tag;
    return b;
  endfunction

  function automatic exp_t mke(input int a, b, c, d, tag, input bit ov);
    exp_t e;
    e.ymr = DW'(a); e.ymi = DW'(b); e.ynr = DW'(c); e.yni = DW'(d);
    e.tag = TGW'(tag); e.ovf = ov;
    return e;
  endfunction

  function automatic int rv();
    if ($urandom_range(0, 7) == 0) return ($urandom_range(0, 1) == 0) ? -2048 : 2047;
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  function automatic beat_t rbeat(input int tag);
    return mkb(rv(), rv(), rv(), rv(), rv(), rv(),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, tag);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive(input beat_t b);
    in_valid = 1'b1;
    xm_re = DW'(b.xmr); xm_im = DW'(b.xmi);
    xn_re = DW'(b.xnr); xn_im = DW'(b.xni);
    tw_re = TW'(b.wr);  tw_im = TW'(b.wi);
    inv = b.inv; scale = b.sc; in_tag = TGW'(b.tag);
  endtask

  task automatic send(input beat_t b, input exp_t e);
    bit ok;
    ok = 1'b0;
    drive(b);
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        ok = 1'b1;
      end
      tick();
    end
    if (!ok) chk($sformatf("accept_timeout tag%0d", b.tag), 0, 1);
  endtask

  // Monitor: a beat is consumed at the next edge when valid and ready are both high.
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk($sformatf("unexpected_beat tag%0d", out_tag), 1, 0);
      end else begin
        me = sb.pop_front();
        chk($sformatf("ym_re tag%0d", me.tag), int'(ym_re), int'(me.ymr));
        chk($sformatf("ym_im tag%0d", me.tag), int'(ym_im), int'(me.ymi));
        chk($sformatf("yn_re tag%0d", me.tag), int'(yn_re), int'(me.ynr));
        chk($sformatf("yn_im tag%0d", me.tag), int'(yn_im), int'(me.yni));
        chk($sformatf("out_tag tag%0d", me.tag), int'(out_tag), int'(me.tag));
        chk($sformatf("ovf tag%0d", me.tag), int'(ovf), int'(me.ovf));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    beat_t b;
    exp_t  e0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    xm_re = '0; xm_im = '0; xn_re = '0; xn_im = '0; tw_re = '0; tw_im = '0;
    inv = 1'b0; scale = 1'b0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst ovf", int'(ovf), 0);
    chk("rst ym_re", int'(ym_re), 0);
    chk("rst out_tag", int'(out_tag), 0);

    // Identity twiddle, then latency: output valid in the third cycle after acceptance.
    send(mkb(100, 50, 200, -30, 2047, 0, 0, 0, 1), mke(300, 20, -100, 80, 1, 0));
    in_valid = 1'b0;
    chk("lat cyc1", int'(out_valid), 0);
    tick();
    chk("lat cyc2", int'(out_valid), 0);
    tick();
    chk("lat cyc3", int'(out_valid), 1);
    repeat (2) tick();

    send(mkb(100, 50, 200, -30, 0, -2048, 0, 0, 2), mke(70, -150, 130, 250, 2, 0));
    send(mkb(100, 50, 200, -30, 0, -2048, 1, 0, 3), mke(130, 250, 70, -150, 3, 0));
`ifdef BUTTERFLY_PIPE_SAT_EN
    send(mkb(2000, 0, 2000, 0, 2047, 0, 0, 0, 4), mke(2047, 0, 1, 0, 4, 1));
`else
    send(mkb(2000, 0, 2000, 0, 2047, 0, 0, 0, 4), mke(-97, 0, 1, 0, 4, 1));
`endif
    send(mkb(2000, 0, 2000, 0, 2047, 0, 0, 1, 5), mke(2000, 0, 1, 0, 5, 0));
    in_valid = 1'b0;
    repeat (5) tick();

    // Stall: pipeline fills with three beats, input side must block and outputs hold.
    out_ready = 1'b0;
    b = rbeat(0);
    e0 = model(b);
    send(b, e0);
    for (int i = 1; i < 3; i++) begin
      b = rbeat(i);
      send(b, model(b));
    end
    drive(rbeat(3));
    for (int i = 0; i < 4; i++) begin
      chk("stall in_ready", int'(in_ready), 0);
      chk("stall out_tag", int'(out_tag), 0);
      chk("stall ym_re", int'(ym_re), int'(e0.ymr));
      tick();
    end
    out_ready = 1'b1;
    for (int i = 3; i < 5; i++) begin
      b = rbeat(i);
      send(b, model(b));
    end
    in_valid = 1'b0;
    repeat (6) tick();
    chk("stall drained", sb.size(), 0);

    // Reset with three beats in flight: none of them may emerge.
    out_ready = 1'b0;
    for (int i = 10; i < 13; i++) begin
      b = rbeat(i);
      send(b, model(b));
    end
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    chk("flush out_valid", int'(out_valid), 0);
    chk("flush in_ready", int'(in_ready), 1);
    chk("flush ovf", int'(ovf), 0);
    chk("flush yn_re", int'(yn_re), 0);
    out_ready = 1'b1;
    repeat (4) tick();
    b = rbeat(13);
    send(b, model(b));
    in_valid = 1'b0;
    tick();
    tick();
    chk("post-rst lat", int'(out_valid), 1);
    tick();
    chk("post-rst drained", sb.size(), 0);

    // Random beats, bubbles and backpressure.
    rnd_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
      b = rbeat(i & 8'hff);
      send(b, model(b));
    end
    in_valid = 1'b0;
    rnd_bp = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && sb.size() != 0; k++) tick();
    chk("random drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
